// File: rtl/align_samples_stream_pkg.sv
// rtl/align_samples_stream_pkg.sv - shared types and sample-alignment function for align_samples_stream
//
// Contents:
//   state_t    : FSM states IDLE / PRIME / RUN / FLUSH
//   cfg_t      : shift configuration {dir, shift}
//   samp_shift : builds one aligned output word from the current and previous input words
//
// samp_shift works on a fixed-width container (word_t) so it can serve any instance
// width; callers zero-extend their words into it and truncate the result back.
// Container limits: up to MAX_SPC samples per word and MAX_W bits per word.
package align_samples_stream_pkg;

  localparam int MAX_SPC = 16;
  localparam int MAX_W   = 1024;
  localparam int SHIFT_W = 4;

  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic               dir;    // 0 = left (toward higher index), 1 = right
    logic [SHIFT_W-1:0] shift;  // shift amount in samples
  } cfg_t;

  // Left N : out[i] = cur[i-N] for i >= N, else prev[spc-N+i]
  // Right N: out[i] = prev[i+N] for i < spc-N, else cur[i-(spc-N)]
  // N = 0  : out = cur in either direction
  // Residual (flush) words are produced by passing cur = 0.
  function automatic word_t samp_shift(
    input word_t              cur,
    input word_t              prev,
    input logic               dir,
    input logic [SHIFT_W-1:0] shift,
    input int                 samp_w,
    input int                 spc
  );
    word_t res;
    word_t mask;
    word_t src;
    int    n;
    int    idx;
    res  = '0;
    mask = (word_t'(1) << samp_w) - word_t'(1);
    n    = int'(shift);
    for (int i = 0; i < MAX_SPC; i++) begin
      src = '0;
      idx = 0;
      if (i < spc) begin
        if (n == 0) begin
          src = cur;
          idx = i;
        end else if (!dir) begin
          if (i >= n) begin
            src = cur;
            idx = i - n;
          end else begin
            src = prev;
            idx = spc - n + i;
          end
        end else begin
          if (i < spc - n) begin
            src = prev;
            idx = i + n;
          end else begin
            src = cur;
            idx = i - (spc - n);
          end
        end
        res = res | (((src >> (idx * samp_w)) & mask) << (i * samp_w));
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/align_samples_mux.sv
// rtl/align_samples_mux.sv - combinational sample selection shared by the RUN and FLUSH paths
//
// Ports:
//   cur   in  SPC*SAMP_W  current input word (ignored when flush=1)
//   prev  in  SPC*SAMP_W  previous word of the packet (zero on the first word)
//   cfg   in  cfg_t       active direction and shift
//   flush in  1           produce the residual word of the stored last word
//   data  out SPC*SAMP_W  aligned word
module align_samples_mux
  import align_samples_stream_pkg::*;
#(
  parameter int SAMP_W = 16,
  parameter int SPC    = 4
) (
  input  logic [SPC*SAMP_W-1:0] cur,
  input  logic [SPC*SAMP_W-1:0] prev,
  input  cfg_t                  cfg,
  input  logic                  flush,
  output logic [SPC*SAMP_W-1:0] data
);

  localparam int W = SPC * SAMP_W;

  logic [W-1:0] cur_eff;

  // A residual word is the normal shift with an all-zero current word, which
  // gives the deterministic zero fill in the vacated samples.
  assign cur_eff = flush ? '0 : cur;

  assign data = W'(samp_shift(word_t'(cur_eff), word_t'(prev), cfg.dir, cfg.shift,
                              SAMP_W, SPC));

endmodule

// File: rtl/align_samples_stream.sv
// rtl/align_samples_stream.sv - packet-aware sample aligner with valid/ready handshake and end-of-packet flush
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_cfg_en, i_dir, i_shift      pending configuration write
//   i_tdata/i_tuser/i_tlast/i_tvalid/i_tready   input stream
//   o_tdata/o_tuser/o_tlast/o_tvalid/o_tready   output stream (single register stage)
//   o_pkt_count, o_flush_count    statistics, present only with ALIGN_SAMPLES_STREAM_STATS_EN
module align_samples_stream
  import align_samples_stream_pkg::*;
#(
  parameter int SAMP_W = 16,
  parameter int SPC    = 4,
  parameter int USER_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cfg_en,
  input  logic                    i_dir,
  input  logic [$clog2(SPC)-1:0]  i_shift,
  input  logic [SPC*SAMP_W-1:0]   i_tdata,
  input  logic [USER_W-1:0]       i_tuser,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [SPC*SAMP_W-1:0]   o_tdata,
  output logic [USER_W-1:0]       o_tuser,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready
`ifdef ALIGN_SAMPLES_STREAM_STATS_EN
  ,
  output logic [31:0]             o_pkt_count,
  output logic [31:0]             o_flush_count
`endif
);

  localparam int W = SPC * SAMP_W;

  state_t            state_q;
  cfg_t              pend_q;
  cfg_t              act_q;
  logic [W-1:0]      prev_q;
  logic [USER_W-1:0] last_user_q;

  cfg_t              cfg_use;
  logic              shift_zero;
  logic              right;
  logic              out_room;
  logic              in_fire;
  logic [W-1:0]      mux_prev;
  logic [W-1:0]      mux_data;

  // In IDLE the beat being accepted is a packet's first word, so it is shifted
  // with the pending config (which becomes active on that same edge).
  assign cfg_use    = (state_q == IDLE) ? pend_q : act_q;
  assign shift_zero = (cfg_use.shift == '0);
  assign right      = cfg_use.dir;

  assign out_room = !o_tvalid || o_tready;
  assign i_tready = !rst && (state_q != FLUSH) && out_room;
  assign in_fire  = i_tvalid && i_tready;

  // No earlier word exists on a packet's first beat: left shifts fill with zero.
  assign mux_prev = (state_q == IDLE) ? '0 : prev_q;

  align_samples_mux #(
    .SAMP_W (SAMP_W),
    .SPC    (SPC)
  ) u_mux (
    .cur   (i_tdata),
    .prev  (mux_prev),
    .cfg   (cfg_use),
    .flush (state_q == FLUSH),
    .data  (mux_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      act_q       <= '0;
      prev_q      <= '0;
      last_user_q <= '0;
      o_tvalid    <= 1'b0;
      o_tlast     <= 1'b0;
      o_tdata     <= '0;
      o_tuser     <= '0;
    end else begin
      if (i_cfg_en) begin
        pend_q.dir   <= i_dir;
        pend_q.shift <= SHIFT_W'(i_shift);
      end

      // Output slot empties when consumed; reloaded below if a beat is produced.
      if (out_room) begin
        o_tvalid <= 1'b0;
      end

      if (in_fire) begin
        prev_q      <= i_tdata;
        last_user_q <= i_tuser;
        if (state_q == IDLE) begin
          act_q <= pend_q;
        end
        // A right shift's first word only primes prev; it produces no beat.
        if ((state_q != IDLE) || !right || shift_zero) begin
          o_tvalid <= 1'b1;
          o_tdata  <= mux_data;
          o_tuser  <= i_tuser;
          o_tlast  <= i_tlast && shift_zero;
        end
        if (i_tlast) begin
          state_q <= shift_zero ? IDLE : FLUSH;
        end else if ((state_q == IDLE) && right && !shift_zero) begin
          state_q <= PRIME;
        end else begin
          state_q <= RUN;
        end
      end else if ((state_q == FLUSH) && out_room) begin
        o_tvalid <= 1'b1;
        o_tdata  <= mux_data;
        o_tuser  <= last_user_q;
        o_tlast  <= 1'b1;
        state_q  <= IDLE;
      end
    end
  end

`ifdef ALIGN_SAMPLES_STREAM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pkt_count   <= '0;
      o_flush_count <= '0;
    end else begin
      if (o_tvalid && o_tready && o_tlast) begin
        o_pkt_count <= o_pkt_count + 32'd1;
      end
      if ((state_q == FLUSH) && out_room) begin
        o_flush_count <= o_flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_align_samples_stream.sv
// tb/tb_align_samples_stream.sv - self-checking bench for align_samples_stream (SAMP_W=8, SPC=4)
module tb_align_samples_stream;

  localparam int SAMP_W = 8;
  localparam int SPC    = 4;
  localparam int USER_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cfg_en = 1'b0;
  logic        i_dir = 1'b0;
  logic [1:0]  i_shift = 2'd0;
  logic [31:0] i_tdata = '0;
  logic [7:0]  i_tuser = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic [7:0]  o_tuser;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
`ifdef ALIGN_SAMPLES_STREAM_STATS_EN
  logic [31:0] o_pkt_count;
  logic [31:0] o_flush_count;
`endif

  always #5 clk = ~clk;

  align_samples_stream #(
    .SAMP_W (SAMP_W),
    .SPC    (SPC),
    .USER_W (USER_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_cfg_en (i_cfg_en),
    .i_dir    (i_dir),
    .i_shift  (i_shift),
    .i_tdata  (i_tdata),
    .i_tuser  (i_tuser),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tuser  (o_tuser),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready)
`ifdef ALIGN_SAMPLES_STREAM_STATS_EN
    ,
    .o_pkt_count   (o_pkt_count),
    .o_flush_count (o_flush_count)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [7:0]  u;
    logic        l;
  } beat_t;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] pkt_d[$];
  logic [7:0]  pkt_u[$];
  beat_t       exp_q[$];
  beat_t       mdl_q[$];
  beat_t       lit_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: flatten the packet into a sample stream, insert N zero samples
  // (left) or drop N samples (right), then re-chunk into zero-padded words.
  task automatic model(input bit dir, input int n);
    logic [7:0]  s[$];
    logic [31:0] w;
    beat_t       b;
    int          m;
    int          nb;
    mdl_q.delete();
    m = pkt_d.size();
    for (int i = 0; i < m; i++) begin
      w = pkt_d[i];
      for (int k = 0; k < SPC; k++) s.push_back(w[8*k +: 8]);
    end
    if (n != 0) begin
      if (!dir) begin
        for (int k = 0; k < n; k++) s.push_front(8'h00);
      end else begin
        for (int k = 0; k < n; k++) void'(s.pop_front());
      end
    end
    nb = (s.size() + SPC - 1) / SPC;
    for (int j = 0; j < nb; j++) begin
      b.d = '0;
      for (int k = 0; k < SPC; k++) begin
        if (j*SPC + k < s.size()) b.d[8*k +: 8] = s[j*SPC + k];
      end
      if (n == 0)      b.u = pkt_u[j];
      else if (!dir)   b.u = pkt_u[(j < m) ? j : m-1];
      else             b.u = pkt_u[(j+1 < m) ? j+1 : m-1];
      b.l = (j == nb-1);
      mdl_q.push_back(b);
    end
  endtask

  task automatic push_lit(input logic [31:0] d, input logic [7:0] u, input logic l);
    beat_t b;
    b.d = d; b.u = u; b.l = l;
    lit_q.push_back(b);
  endtask

  // Pins the model to the hand-computed beats, then expects the literal beats.
  task automatic pin_and_expect(input string name);
    chk({name, "_model_len"}, 64'(mdl_q.size()), 64'(lit_q.size()));
    for (int i = 0; i < lit_q.size(); i++) begin
      if (i < mdl_q.size())
        chk({name, "_model_beat"}, {mdl_q[i].d, mdl_q[i].u, mdl_q[i].l},
            {lit_q[i].d, lit_q[i].u, lit_q[i].l});
      exp_q.push_back(lit_q[i]);
    end
    lit_q.delete();
  endtask

  task automatic expect_model();
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
  endtask

  task automatic set_cfg(input bit dir, input int n);
    @(posedge clk); #1;
    i_cfg_en = 1'b1; i_dir = dir; i_shift = n[1:0];
    @(posedge clk); #1;
    i_cfg_en = 1'b0;
  endtask

  task automatic send_packet(input int mid_idx, input bit mid_dir, input int mid_n,
                             input int stop_after, input bit exp_v1);
    int cnt;
    bit acc;
    for (int i = 0; i < pkt_d.size(); i++) begin
      if (stop_after >= 0 && i == stop_after) break;
      i_tvalid = 1'b1;
      i_tdata  = pkt_d[i];
      i_tuser  = pkt_u[i];
      i_tlast  = (stop_after < 0) && (i == pkt_d.size() - 1);
      if (i == mid_idx) begin
        i_cfg_en = 1'b1; i_dir = mid_dir; i_shift = mid_n[1:0];
      end
      cnt = 0; acc = 0;
      while (!acc && cnt < 100) begin
        @(negedge clk);
        if (i_tready) acc = 1; else cnt++;
      end
      if (!acc) begin
        vectors++; miscompares++;
        $display("FAIL handshake_timeout: i_tready stayed %b, required 1", i_tready);
        i_tvalid = 1'b0; i_tlast = 1'b0; i_cfg_en = 1'b0;
        return;
      end
      @(posedge clk); #1;
      i_cfg_en = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0;
      if (i == 0) chk("first_beat_latency", 64'(o_tvalid), 64'(exp_v1));
    end
  endtask

  task automatic drain(input string name);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 60) begin
      @(posedge clk); cnt++;
    end
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1 chk({name, "_idle_after"}, 64'(o_tvalid), 64'd0);
  endtask

  // Per-cycle compare: any valid output must equal the expected head, both on
  // transfer and while held under backpressure.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && o_tvalid) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_beat: got data %h user %h last %b, required no beat",
                   o_tdata, o_tuser, o_tlast);
        end else begin
          chk("out_beat", {o_tdata, o_tuser, o_tlast}, {exp_q[0].d, exp_q[0].u, exp_q[0].l});
          if (o_tready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_o_tlast",  64'(o_tlast),  64'd0);
    chk("rst_o_tdata",  64'(o_tdata),  64'd0);
    chk("rst_o_tuser",  64'(o_tuser),  64'd0);
    chk("rst_i_tready", 64'(i_tready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Left 1
    set_cfg(1'b0, 1);
    pkt_d = '{32'h03020100, 32'h07060504}; pkt_u = '{8'hA0, 8'hA1};
    model(1'b0, 1);
    push_lit(32'h02010000, 8'hA0, 1'b0);
    push_lit(32'h06050403, 8'hA1, 1'b0);
    push_lit(32'h00000007, 8'hA1, 1'b1);
    pin_and_expect("left1");
    send_packet(-1, 1'b0, 0, -1, 1'b1);
    drain("left1");

    // Right 1
    set_cfg(1'b1, 1);
    model(1'b1, 1);
    push_lit(32'h04030201, 8'hA1, 1'b0);
    push_lit(32'h00070605, 8'hA1, 1'b1);
    pin_and_expect("right1");
    send_packet(-1, 1'b0, 0, -1, 1'b0);
    drain("right1");

    // N = 0 pass-through, random data and user
    set_cfg(1'b1, 0);
    pkt_d.delete(); pkt_u.delete();
    for (int i = 0; i < 3; i++) begin
      pkt_d.push_back($urandom);
      pkt_u.push_back(8'($urandom));
    end
    model(1'b1, 0);
    expect_model();
    send_packet(-1, 1'b0, 0, -1, 1'b1);
    drain("pass3");

    // Right 2, single word
    set_cfg(1'b1, 2);
    pkt_d = '{32'hDDCCBBAA}; pkt_u = '{8'h55};
    model(1'b1, 2);
    push_lit(32'h0000DDCC, 8'h55, 1'b1);
    pin_and_expect("right2_single");
    send_packet(-1, 1'b0, 0, -1, 1'b0);
    drain("right2_single");

    // Right 3 with backpressure during FLUSH
    set_cfg(1'b1, 3);
    pkt_d = '{32'h03020100, 32'h07060504}; pkt_u = '{8'h10, 8'h11};
    model(1'b1, 3);
    push_lit(32'h06050403, 8'h11, 1'b0);
    push_lit(32'h00000007, 8'h11, 1'b1);
    pin_and_expect("right3");
    send_packet(-1, 1'b0, 0, -1, 1'b0);
    o_tready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("flush_stall_i_tready", 64'(i_tready), 64'd0);
      chk("flush_stall_o_tvalid", 64'(o_tvalid), 64'd1);
    end
    @(posedge clk); #1 o_tready = 1'b1;
    drain("right3");

    // Config write mid-packet, then back-to-back next packet
    set_cfg(1'b1, 1);
    pkt_d = '{32'h13121110, 32'h17161514, 32'h1B1A1918}; pkt_u = '{8'h20, 8'h21, 8'h22};
    model(1'b1, 1);
    expect_model();
    send_packet(1, 1'b0, 2, -1, 1'b0);
    pkt_d = '{32'h23222120, 32'h27262524}; pkt_u = '{8'h30, 8'h31};
    model(1'b0, 2);
    push_lit(32'h21200000, 8'h30, 1'b0);
    push_lit(32'h25242322, 8'h31, 1'b0);
    push_lit(32'h00002726, 8'h31, 1'b1);
    pin_and_expect("left2_next");
    send_packet(-1, 1'b0, 0, -1, 1'b1);
    drain("cfg_mid");

    // Reset mid-packet discards partial data and config
    set_cfg(1'b1, 1);
    pkt_d = '{32'h33323130, 32'h37363534}; pkt_u = '{8'h40, 8'h41};
    send_packet(-1, 1'b0, 0, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("midrst_i_tready", 64'(i_tready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    pkt_d = '{32'h43424140, 32'h47464544}; pkt_u = '{8'h50, 8'h51};
    model(1'b0, 0);
    expect_model();
    send_packet(-1, 1'b0, 0, -1, 1'b1);
    drain("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/align_samples_stream.md
Name: align_samples_stream

Overview:
- Packet-aware successor to align_samples: shifts samples across word boundaries, left or right by 0..SPC-1 samples.
- Adds full valid/ready handshaking with backpressure, per-packet configuration, deterministic zero fill and an end-of-packet flush of residual samples.
- Sits in the radio datapath between the sample-rate logic and the RFNoC packetizer, where burst starts are sample-aligned.

Parameters:
- SAMP_W, 16, bits per sample.
- SPC, 4, samples per word; power of 2, ≥2.
- USER_W, 8, sideband bits carried per word.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- i_cfg_en  in  1  writes a pending configuration.
- i_dir  in  1  0 = left shift (toward higher sample index), 1 = right shift.
- i_shift  in  $clog2(SPC)  shift amount N in samples.
- i_tdata  in  SPC*SAMP_W  input word; sample 0 is in the LSBs.
- i_tuser  in  USER_W  input sideband.
- i_tlast  in  1  last word of packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  SPC*SAMP_W  output word.
- o_tuser  out  USER_W  output sideband.
- o_tlast  out  1  last word of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.

Behaviour:
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, o_tuser=0; i_tready=0 while rst is asserted.
- Reset clears active and pending config to dir=0, N=0 and returns the FSM to IDLE.
- Reset mid-packet discards all partial data; no output beat is emitted for it.
- Config:
  - i_cfg_en loads a pending register at any time; the last write wins.
  - Pending config copies to active config only on the first accepted beat of a packet, while in IDLE.
  - A write mid-packet never affects the current packet.
- Handshake:
  - Output is a single register stage.
  - i_tready = (state != FLUSH) && (!o_tvalid || o_tready).
  - A beat transfers when valid && ready.
  - o_tdata/o_tuser/o_tlast are held stable while o_tvalid && !o_tready.
- Shift rules, with prev = previous input word of the same packet:
  - Left N: out[N..SPC-1] = cur[0..SPC-1-N]; out[0..N-1] = prev[SPC-N..SPC-1]. On the first word those low samples are 0.
  - Right N: out[0..SPC-1-N] = prev[N..SPC-1]; out[SPC-N..SPC-1] = cur[0..N-1]. The first N samples of the packet are dropped.
  - N=0: pass-through in either direction.
  - o_tuser = tuser of cur; flush beats use the last word's tuser.
- FSM states:
  - IDLE: accept first beat and latch config.
    - Left, or N=0: emit a beat; go to RUN.
    - Right, N>0: store the word with no output; go to PRIME.
    - If that beat has tlast: N=0 → emit with o_tlast, stay IDLE; left N>0 → emit, go FLUSH; right N>0 → go FLUSH.
  - PRIME: behaves as RUN, with a word already stored.
  - RUN: emit one beat per input beat. On tlast: N=0 → o_tlast=1, go IDLE; N>0 → go FLUSH.
  - FLUSH: input is stalled; emit one residual beat with o_tlast=1, then go IDLE.
    - Left residual: out[0..N-1] = last[SPC-N..SPC-1], rest 0.
    - Right residual: out[0..SPC-1-N] = last[N..SPC-1], rest 0.
- Latency:
  - Left, or N=0: 1 cycle from input accept to o_tvalid.
  - Right N>0: output word k appears 1 cycle after input word k+1 is accepted.
- Output beat counts for an M-word packet:
  - Left N>0: M+1 beats.
  - Right, or N=0: M beats.
- Back-to-back packets: the flush beat and the next packet's first beat are on consecutive cycles when o_tready=1.

Optional Feature:
- Macro: ALIGN_SAMPLES_STREAM_STATS_EN.
- Defined: adds output o_pkt_count (32 bits) and output o_flush_count (32 bits).
  - o_pkt_count counts completed output packets (o_tlast beats).
  - o_flush_count counts emitted flush beats.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists.

Decomposition:
- Package align_samples_stream_pkg:
  - state enum {IDLE, PRIME, RUN, FLUSH}.
  - cfg_t struct {dir, shift}.
  - Function samp_shift(cur, prev, dir, shift) that returns the aligned word.
- Sub-module align_samples_mux: combinational, implements the left/right/residual selection from cur, prev, cfg and a flush flag, and is shared by the RUN and FLUSH paths.

Test Plan (SAMP_W=8, SPC=4):
- Left 1, in 0x03020100, 0x07060504+tlast → out 0x02010000, 0x06050403, then 0x00000007 with o_tlast=1.
- Right 1, same input → out 0x04030201, then 0x00070605 with o_tlast=1; exactly 2 beats.
- N=0, 3-word packet with random data and user → identical output at 1-cycle latency; o_tlast on the 3rd beat.
- Right 2, single-word packet 0xDDCCBBAA+tlast → one beat 0x0000DDCC with o_tlast=1.
- Right 3, o_tready held low for 5 cycles during FLUSH → data stable, i_tready=0, single flush beat after release.
- Write left 2 mid-packet while running right 1 → current packet stays right 1 and next packet is left 2; rst mid-packet → o_tvalid=0, next packet uses N=0.
